// File: rtl/int_ctrl.sv
// Wishbone-slave interrupt controller: synchronises device requests, latches them per
// edge/level mode, masks them and presents a registered INT plus priority-encoded CAUSE.
module int_ctrl #(
  parameter int N_SRC    = 6,
  parameter bit PRIO_LOW = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] irq_in,
  input  logic             STB,
  input  logic             WE,
  input  logic [31:0]      ADDR,
  input  logic [31:0]      DAT_I,
  output logic [31:0]      DAT_O,
  output logic             ACK,
  output logic             INT,
  output logic [31:0]      CAUSE
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_WAIT
  } state_t;

  state_t state;

  logic [N_SRC-1:0] sync1;
  logic [N_SRC-1:0] s;
  logic [N_SRC-1:0] prev;
  logic [N_SRC-1:0] pending;
  logic [N_SRC-1:0] mask;
  logic [N_SRC-1:0] edge_mode;

  logic [N_SRC-1:0] active;
  logic [N_SRC-1:0] set_vec;
  logic [N_SRC-1:0] clr_vec;
  logic [N_SRC-1:0] clr_eff;
  logic [N_SRC-1:0] win_onehot;
  logic [4:0]       win_idx;
  logic             any_active;
  logic [31:0]      rdata;
  logic             unused_bits;

  assign active      = pending & mask;
  assign set_vec     = s & ~prev;
  assign clr_eff     = (state == S_ACCESS) ? clr_vec : '0;
  assign unused_bits = ^{ADDR[31:4], ADDR[1:0], DAT_I};

  // Priority encoder: the last match in the scan order is the winner.
  always_comb begin
    win_idx    = '0;
    win_onehot = '0;
    any_active = 1'b0;
    if (PRIO_LOW) begin
      for (int i = N_SRC - 1; i >= 0; i--) begin
        if (active[i]) begin
          win_idx         = 5'(i);
          win_onehot      = '0;
          win_onehot[i]   = 1'b1;
          any_active      = 1'b1;
        end
      end
    end else begin
      for (int i = 0; i < N_SRC; i++) begin
        if (active[i]) begin
          win_idx         = 5'(i);
          win_onehot      = '0;
          win_onehot[i]   = 1'b1;
          any_active      = 1'b1;
        end
      end
    end
  end

  // Read mux and clear requests; clears only take effect in the ACCESS cycle.
  always_comb begin
    rdata   = '0;
    clr_vec = '0;
    case (ADDR[3:2])
      2'd0: begin
        rdata = 32'(pending);
        if (WE) clr_vec = DAT_I[N_SRC-1:0] & edge_mode;
      end
      2'd1: rdata = 32'(mask);
      2'd2: rdata = 32'(edge_mode);
      default: begin
        if (!WE) begin
          if (any_active) begin
            rdata   = 32'(win_idx);
            clr_vec = win_onehot & edge_mode;
          end else begin
            rdata = 32'hFFFF_FFFF;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      sync1     <= '0;
      s         <= '0;
      prev      <= '0;
      pending   <= '0;
      mask      <= '0;
      edge_mode <= '1;
      ACK       <= 1'b0;
      DAT_O     <= '0;
      INT       <= 1'b0;
      CAUSE     <= '0;
    end else begin
      sync1 <= irq_in;
      s     <= sync1;
      prev  <= s;
      // A new edge overrides a same-cycle clear.
      pending <= (edge_mode & ((pending & ~clr_eff) | set_vec)) | (~edge_mode & s);
      INT     <= any_active;
      CAUSE   <= any_active ? 32'(win_idx) : '0;

      case (state)
        S_IDLE: begin
          ACK   <= 1'b0;
          DAT_O <= '0;
          if (STB) state <= S_ACCESS;
        end
        S_ACCESS: begin
          ACK   <= 1'b1;
          DAT_O <= WE ? 32'h0 : rdata;
          if (WE) begin
            case (ADDR[3:2])
              2'd1:    mask      <= DAT_I[N_SRC-1:0];
              2'd2:    edge_mode <= DAT_I[N_SRC-1:0];
              default: ;
            endcase
          end
          state <= S_WAIT;
        end
        S_WAIT: begin
          ACK   <= 1'b0;
          DAT_O <= '0;
          if (!STB) state <= S_IDLE;
        end
        default: begin
          ACK   <= 1'b0;
          DAT_O <= '0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl: reset, latency, priority, level/mask, bus handshake and
// collision cases, each with hand-computed expectations.
module tb_int_ctrl;

  localparam logic [1:0] REG_PENDING = 2'd0;
  localparam logic [1:0] REG_MASK    = 2'd1;
  localparam logic [1:0] REG_EDGE    = 2'd2;
  localparam logic [1:0] REG_CLAIM   = 2'd3;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  irq_in;
  logic        STB;
  logic        WE;
  logic [31:0] ADDR;
  logic [31:0] DAT_I;
  logic [31:0] DAT_O;
  logic        ACK;
  logic        INT;
  logic [31:0] CAUSE;

  int total = 0;
  int bad   = 0;

  logic [31:0] rd;
  int          ack_count;
  logic [31:0] held_data;

  int_ctrl #(.N_SRC(6), .PRIO_LOW(1'b1)) dut (
    .clk    (clk),
    .rst    (rst),
    .irq_in (irq_in),
    .STB    (STB),
    .WE     (WE),
    .ADDR   (ADDR),
    .DAT_I  (DAT_I),
    .DAT_O  (DAT_O),
    .ACK    (ACK),
    .INT    (INT),
    .CAUSE  (CAUSE)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One complete bus access; returns the data seen while ACK was high.
  task automatic applyStimulus(input logic we, input logic [1:0] reg_idx,
                               input logic [31:0] wdata, output logic [31:0] rdata);
    logic acked;
    acked = 1'b0;
    rdata = '0;
    STB   = 1'b1;
    WE    = we;
    ADDR  = {28'h0, reg_idx, 2'b00};
    DAT_I = wdata;
    for (int i = 0; i < 8 && !acked; i++) begin
      @(posedge clk);
      #1;
      if (ACK) begin
        acked = 1'b1;
        rdata = DAT_O;
      end
    end
    STB = 1'b0;
    WE  = 1'b0;
    checkOutput("ack_seen", 32'(acked), 32'd1);
    tick(1);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst    = 1'b1;
    irq_in = '0;
    STB    = 1'b0;
    WE     = 1'b0;
    ADDR   = '0;
    DAT_I  = '0;

    // Reset state
    tick(3);
    checkOutput("rst_ack",   32'(ACK),   32'd0);
    checkOutput("rst_int",   32'(INT),   32'd0);
    checkOutput("rst_cause", CAUSE,      32'd0);
    checkOutput("rst_dato",  DAT_O,      32'd0);
    rst = 1'b0;
    tick(1);
    applyStimulus(1'b0, REG_EDGE, 32'h0, rd);
    checkOutput("rst_edge", rd, 32'h3F);
    applyStimulus(1'b0, REG_MASK, 32'h0, rd);
    checkOutput("rst_mask", rd, 32'h0);
    applyStimulus(1'b0, REG_PENDING, 32'h0, rd);
    checkOutput("rst_pending", rd, 32'h0);
    applyStimulus(1'b0, REG_CLAIM, 32'h0, rd);
    checkOutput("claim_empty", rd, 32'hFFFF_FFFF);

    // Latency: unused high bits of MASK read as zero
    applyStimulus(1'b1, REG_MASK, 32'hFFFF_FFFF, rd);
    applyStimulus(1'b0, REG_MASK, 32'h0, rd);
    checkOutput("mask_width", rd, 32'h3F);
    irq_in = 6'b001000;
    tick(1);
    irq_in = '0;
    tick(2);
    checkOutput("lat_int_early", 32'(INT), 32'd0);
    tick(1);
    checkOutput("lat_int", 32'(INT), 32'd1);
    checkOutput("lat_cause", CAUSE, 32'd3);
    applyStimulus(1'b0, REG_CLAIM, 32'h0, rd);
    checkOutput("lat_claim", rd, 32'd3);
    checkOutput("lat_int_clr", 32'(INT), 32'd0);
    checkOutput("lat_cause_clr", CAUSE, 32'd0);

    // Priority between simultaneous edges
    irq_in = 6'b101000;
    tick(4);
    checkOutput("prio_int", 32'(INT), 32'd1);
    checkOutput("prio_cause", CAUSE, 32'd3);
    applyStimulus(1'b0, REG_CLAIM, 32'h0, rd);
    checkOutput("prio_claim0", rd, 32'd3);
    checkOutput("prio_cause2", CAUSE, 32'd5);
    applyStimulus(1'b0, REG_CLAIM, 32'h0, rd);
    checkOutput("prio_claim1", rd, 32'd5);
    applyStimulus(1'b0, REG_CLAIM, 32'h0, rd);
    checkOutput("prio_claim2", rd, 32'hFFFF_FFFF);
    checkOutput("prio_int_off", 32'(INT), 32'd0);
    irq_in = '0;
    tick(3);

    // Level mode and masking
    applyStimulus(1'b1, REG_MASK, 32'h0, rd);
    applyStimulus(1'b1, REG_EDGE, 32'h0, rd);
    irq_in = 6'b100000;
    tick(4);
    checkOutput("lvl_masked_int", 32'(INT), 32'd0);
    applyStimulus(1'b0, REG_PENDING, 32'h0, rd);
    checkOutput("lvl_pending", rd, 32'h20);
    applyStimulus(1'b1, REG_MASK, 32'h20, rd);
    checkOutput("lvl_int", 32'(INT), 32'd1);
    checkOutput("lvl_cause", CAUSE, 32'd5);
    applyStimulus(1'b1, REG_PENDING, 32'h20, rd);
    applyStimulus(1'b0, REG_PENDING, 32'h0, rd);
    checkOutput("lvl_w1c_ignored", rd, 32'h20);
    irq_in = '0;
    tick(4);
    checkOutput("lvl_int_drop", 32'(INT), 32'd0);
    applyStimulus(1'b0, REG_PENDING, 32'h0, rd);
    checkOutput("lvl_pending_drop", rd, 32'h0);

    // Handshake: STB held high across a claim read
    applyStimulus(1'b1, REG_EDGE, 32'h3F, rd);
    applyStimulus(1'b1, REG_MASK, 32'h3F, rd);
    irq_in = 6'b010010;
    tick(4);
    irq_in = '0;
    ack_count = 0;
    held_data = '0;
    STB  = 1'b1;
    WE   = 1'b0;
    ADDR = {28'h0, REG_CLAIM, 2'b00};
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (ACK) begin
        ack_count++;
        held_data = DAT_O;
      end
    end
    STB = 1'b0;
    tick(2);
    checkOutput("hs_ack_count", 32'(ack_count), 32'd1);
    checkOutput("hs_claim", held_data, 32'd1);
    applyStimulus(1'b0, REG_PENDING, 32'h0, rd);
    checkOutput("hs_pending", rd, 32'h10);
    checkOutput("hs_cause", CAUSE, 32'd4);
    applyStimulus(1'b1, REG_CLAIM, 32'h0, rd);
    applyStimulus(1'b0, REG_PENDING, 32'h0, rd);
    checkOutput("hs_claim_wr_ignored", rd, 32'h10);
    applyStimulus(1'b0, REG_CLAIM, 32'h0, rd);
    checkOutput("hs_claim_last", rd, 32'd4);

    // Collision: W1C lands in the same cycle the edge sets the bit
    irq_in = 6'b000100;
    tick(1);
    applyStimulus(1'b1, REG_PENDING, 32'h4, rd);
    applyStimulus(1'b0, REG_PENDING, 32'h0, rd);
    checkOutput("col_set_wins", rd, 32'h4);
    irq_in = '0;
    tick(2);
    checkOutput("col_int", 32'(INT), 32'd1);

    // Reset during ACCESS discards the write
    STB   = 1'b1;
    WE    = 1'b1;
    ADDR  = {28'h0, REG_EDGE, 2'b00};
    DAT_I = 32'h0;
    tick(1);
    rst = 1'b1;
    tick(1);
    checkOutput("rstacc_ack", 32'(ACK), 32'd0);
    checkOutput("rstacc_int", 32'(INT), 32'd0);
    checkOutput("rstacc_cause", CAUSE, 32'd0);
    rst = 1'b0;
    STB = 1'b0;
    WE  = 1'b0;
    tick(1);
    applyStimulus(1'b0, REG_EDGE, 32'h0, rd);
    checkOutput("rstacc_edge", rd, 32'h3F);
    applyStimulus(1'b0, REG_MASK, 32'h0, rd);
    checkOutput("rstacc_mask", rd, 32'h0);
    applyStimulus(1'b0, REG_PENDING, 32'h0, rd);
    checkOutput("rstacc_pending", rd, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
